// File: rtl/jtag_tap_bsr.sv
// Oversampled IEEE 1149.1 TAP controller with boundary-scan register, all in the clk_50MHz domain.
// Define JTAG_IDCODE_EN to include the IDCODE instruction (001) and its 32-bit data register.
module jtag_tap_bsr #(
  parameter int          IR_WIDTH   = 3,
  parameter int          N_IN       = 6,
  parameter int          N_OUT      = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             TCK,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_oe,
  input  logic [N_IN-1:0]  Par_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] Par_out,
  output logic [3:0]       tap_state
);

  localparam int N_BSR = N_IN + N_OUT;
  localparam logic [2:0] OP_EXTEST = 3'b000;
  localparam logic [2:0] OP_SAMPLE = 3'b010;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [2:0] OP_IDCODE = 3'b001;
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(3'b001);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = {IR_WIDTH{1'b1}};
`endif

  typedef enum logic [3:0] {
    TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3, SH_DR = 4'd4,
    EX1_DR = 4'd5, PAUSE_DR = 4'd6, EX2_DR = 4'd7, UP_DR = 4'd8,
    SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11, EX1_IR = 4'd12,
    PAUSE_IR = 4'd13, EX2_IR = 4'd14, UP_IR = 4'd15
  } tap_state_t;

  tap_state_t state, state_nxt;
  logic [2:0] tck_sync;
  logic [1:0] tms_sync, tdi_sync;
  logic       tck_rise, tck_fall, tms_s, tdi_s;
  logic [IR_WIDTH-1:0] ir_shift, ir_latch;
  logic [N_BSR-1:0]    bsr_shift, bsr_upd;
  logic       byp, tdo_q, tdo_nxt;
  logic       ir_hi_zero, is_extest, is_sample, bsr_sel;
  logic [N_OUT-1:0] par_out_q;

  // The third TCK flop exists only for edge detection, so rise and fall are mutually exclusive.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
    end else begin
      tck_sync <= {tck_sync[1:0], TCK};
      tms_sync <= {tms_sync[0], TMS};
      tdi_sync <= {tdi_sync[0], TDI};
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_sync[2];
  assign tck_fall = ~tck_sync[1] & tck_sync[2];
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];

  always_ff @(posedge clk_50MHz) begin
    if (rst)           state <= TLR;
    else if (tck_rise) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms_s ? TLR    : RTI;
      RTI:      state_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:   state_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = tms_s ? UP_DR  : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_s ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = tms_s ? UP_DR  : SH_DR;
      UP_DR:    state_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:   state_nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = tms_s ? UP_IR  : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_s ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = tms_s ? UP_IR  : SH_IR;
      UP_IR:    state_nxt = tms_s ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Any set bit above the 3-bit opcode field forces BYPASS.
  assign ir_hi_zero = ((ir_latch >> 3) == '0);
  assign is_extest  = ir_hi_zero && (ir_latch[2:0] == OP_EXTEST);
  assign is_sample  = ir_hi_zero && (ir_latch[2:0] == OP_SAMPLE);
  assign bsr_sel    = is_extest || is_sample;

`ifdef JTAG_IDCODE_EN
  logic        is_idcode;
  logic [31:0] id_shift;
  assign is_idcode = ir_hi_zero && (ir_latch[2:0] == OP_IDCODE);

  always_ff @(posedge clk_50MHz) begin
    if (rst) id_shift <= '0;
    else if (tck_rise && is_idcode) begin
      if (state == CAP_DR)     id_shift <= IDCODE_VAL;
      else if (state == SH_DR) id_shift <= {tdi_s, id_shift[31:1]};
    end
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
`endif

  always_comb begin
    tdo_nxt = 1'b0;
    if (state == SH_IR) tdo_nxt = ir_shift[0];
    else if (state == SH_DR) begin
      if (bsr_sel) tdo_nxt = bsr_shift[0];
`ifdef JTAG_IDCODE_EN
      else if (is_idcode) tdo_nxt = id_shift[0];
`endif
      else tdo_nxt = byp;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      ir_shift  <= '0;
      ir_latch  <= IR_RESET;
      bsr_shift <= '0;
      bsr_upd   <= '0;
      byp       <= 1'b0;
      tdo_q     <= 1'b0;
      par_out_q <= core_out;
    end else begin
      if (tck_rise) begin
        case (state)
          CAP_IR: ir_shift <= IR_CAPTURE;
          SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          CAP_DR: begin
            byp <= 1'b0;
            if (bsr_sel) bsr_shift <= {core_out, Par_in};
          end
          SH_DR: begin
            byp <= tdi_s;
            if (bsr_sel) bsr_shift <= {tdi_s, bsr_shift[N_BSR-1:1]};
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        tdo_q <= tdo_nxt;
        if (state == UP_IR) ir_latch <= ir_shift;
        if (state == UP_DR && bsr_sel) bsr_upd <= bsr_shift;
      end
      if (state == TLR) ir_latch <= IR_RESET;
      // Uses the latch value from the previous cycle, hence one cycle behind any update.
      par_out_q <= is_extest ? bsr_upd[N_BSR-1:N_IN] : core_out;
    end
  end

  assign TDO       = tdo_q;
  assign TDO_oe    = (state == SH_IR) || (state == SH_DR);
  assign tap_state = state;
  assign core_in   = Par_in;
  assign Par_out   = par_out_q;

endmodule

// File: tb/tb_jtag_tap_bsr.sv
// Directed bench for jtag_tap_bsr: TAP navigation, IR load, SAMPLE/PRELOAD, EXTEST, BYPASS, IDCODE.
module tb_jtag_tap_bsr;

  logic       clk = 1'b0;
  logic       rst, TCK, TMS, TDI;
  logic       TDO, TDO_oe;
  logic [5:0] Par_in, core_in;
  logic [3:0] core_out, Par_out, tap_state;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  jtag_tap_bsr dut (
    .clk_50MHz(clk), .rst(rst), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_oe(TDO_oe), .Par_in(Par_in), .core_in(core_in),
    .core_out(core_out), .Par_out(Par_out), .tap_state(tap_state)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One TCK period; tdo_v is sampled 4 clk cycles after the falling edge.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    TMS = tms_v;
    TDI = tdi_v;
    repeat (4) @(negedge clk);
    TCK = 1'b1;
    repeat (5) @(negedge clk);
    TCK = 1'b0;
    repeat (4) @(negedge clk);
    tdo_v = TDO;
  endtask

  task automatic tms_step(input logic tms_v);
    logic d;
    tck_cycle(tms_v, 1'b0, d);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // From RTI: load the IR, return the captured bits (LSB first), end in RTI.
  task automatic shift_ir(input logic [2:0] v, output logic [2:0] out);
    logic t;
    tms_step(1'b1); tms_step(1'b1); tms_step(1'b0);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) begin
      out[i] = t;
      tck_cycle(i == 2, v[i], t);
    end
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  // From RTI: shift n DR bits, return TDO bits and Par_out right after the UpDR fall, end in RTI.
  task automatic shift_dr(input logic [31:0] v, input int n, output logic [31:0] out,
                          output logic [3:0] po_upd);
    logic t;
    out = '0;
    tms_step(1'b1); tms_step(1'b0);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      out[i] = t;
      tck_cycle(i == n - 1, v[i], t);
    end
    tms_step(1'b1);
    po_upd = Par_out;
    tms_step(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0;
    Par_in = 6'b101101; core_out = 4'b1010;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", tap_state); end
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", TDO); end
    checks++; if (TDO_oe !== 1'b0) begin errors++; $display("FAIL reset_tdo_oe: got %b expected 0", TDO_oe); end
    checks++; if (Par_out !== 4'b1010) begin errors++; $display("FAIL reset_par_out: got %b expected 1010", Par_out); end
    checks++; if (core_in !== 6'b101101) begin errors++; $display("FAIL core_in: got %b expected 101101", core_in); end
    core_out = 4'b0110;
    repeat (2) @(negedge clk);
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL par_out_follow: got %b expected 0110", Par_out); end
    tms_step(1'b0);
    checks++; if (tap_state !== 4'd1) begin errors++; $display("FAIL state_rti: got %0d expected 1", tap_state); end
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    checks++; if (tap_state !== 4'd4) begin errors++; $display("FAIL state_shdr: got %0d expected 4", tap_state); end
    checks++; if (TDO_oe !== 1'b1) begin errors++; $display("FAIL shdr_tdo_oe: got %b expected 1", TDO_oe); end
    for (int i = 0; i < 5; i++) tms_step(1'b1);
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL tms5_state: got %0d expected 0", tap_state); end
    checks++; if (TDO_oe !== 1'b0) begin errors++; $display("FAIL tms5_tdo_oe: got %b expected 0", TDO_oe); end
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL tms5_par_out: got %b expected 0110", Par_out); end
    tms_step(1'b0);
  endtask

  task automatic test_ir_capture();
    logic [2:0] out;
    shift_ir(3'b010, out);
    checks++; if (out !== 3'b001) begin errors++; $display("FAIL ir_capture: got %b expected 001", out); end
    checks++; if (tap_state !== 4'd1) begin errors++; $display("FAIL ir_end_state: got %0d expected 1", tap_state); end
  endtask

  task automatic test_sample();
    logic [31:0] out;
    logic [3:0]  po;
    logic [0:0]  e;
    Par_in = 6'b101101; core_out = 4'b0110;
    shift_dr(32'h0, 10, out, po);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out[i] !== e[0]) begin errors++; $display("FAIL sample_tdo[%0d]: got %b expected %b", i, out[i], e[0]); end
    end
    checks++; if (po !== 4'b0110) begin errors++; $display("FAIL sample_par_out_upd: got %b expected 0110", po); end
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL sample_par_out: got %b expected 0110", Par_out); end
  endtask

  task automatic test_extest();
    logic [31:0] out;
    logic [2:0]  ir_out;
    logic [3:0]  po;
    shift_dr(32'h200, 10, out, po);
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL preload_par_out: got %b expected 0110", Par_out); end
    shift_ir(3'b000, ir_out);
    checks++; if (ir_out !== 3'b001) begin errors++; $display("FAIL extest_ir_capture: got %b expected 001", ir_out); end
    checks++; if (Par_out !== 4'b1000) begin errors++; $display("FAIL extest_preloaded: got %b expected 1000", Par_out); end
    shift_dr(32'h120, 10, out, po);
    checks++; if (out[9:0] !== 10'b01_1010_1101) begin errors++; $display("FAIL extest_capture: got %b expected 0110101101", out[9:0]); end
    checks++; if (po !== 4'b0100) begin errors++; $display("FAIL extest_par_out: got %b expected 0100", po); end
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL rti_tdo: got %b expected 0", TDO); end
  endtask

  task automatic test_reset_mid_shift();
    logic [2:0] ir_out;
    logic d;
    tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
    tck_cycle(1'b0, 1'b1, d);
    tck_cycle(1'b0, 1'b1, d);
    pulse_rst();
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", tap_state); end
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL midrst_tdo: got %b expected 0", TDO); end
    checks++; if (TDO_oe !== 1'b0) begin errors++; $display("FAIL midrst_tdo_oe: got %b expected 0", TDO_oe); end
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL midrst_par_out: got %b expected 0110", Par_out); end
    tms_step(1'b0);
    shift_ir(3'b000, ir_out);
    checks++; if (Par_out !== 4'b0000) begin errors++; $display("FAIL midrst_upd_cleared: got %b expected 0000", Par_out); end
  endtask

  task automatic test_bypass();
    logic [31:0] out;
    logic [2:0]  ir_out;
    logic [3:0]  po;
    shift_ir(3'b110, ir_out);
    checks++; if (ir_out !== 3'b001) begin errors++; $display("FAIL bypass_ir_capture: got %b expected 001", ir_out); end
    shift_dr(32'hD, 4, out, po);
    checks++; if (out[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_tdo: got %b expected 1010", out[3:0]); end
    checks++; if (Par_out !== 4'b0110) begin errors++; $display("FAIL bypass_par_out: got %b expected 0110", Par_out); end
  endtask

  task automatic test_idcode();
    logic [31:0] out;
    logic [3:0]  po;
    pulse_rst();
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL id_reset_state: got %0d expected 0", tap_state); end
    tms_step(1'b0);
    shift_dr(32'h8000_F00D, 32, out, po);
`ifdef JTAG_IDCODE_EN
    checks++; if (out !== 32'h1000_0001) begin errors++; $display("FAIL idcode: got %h expected 10000001", out); end
`else
    checks++; if (out !== 32'h0001_E01A) begin errors++; $display("FAIL reset_bypass: got %h expected 0001e01a", out); end
`endif
  endtask

  initial begin
    test_reset();
    test_ir_capture();
    test_sample();
    test_extest();
    test_reset_mid_shift();
    test_bypass();
    test_idcode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
